// File: rtl/move_collector.sv
`default_nettype none
// ============================================================================
// Module   : move_collector
// Purpose  : Turn-based move capture for a 3x3 board. Synchronizes and
//            debounces the nine cell buttons, alternates P1/P2, rejects
//            illegal moves, and builds the mark/occupancy bitmaps read by an
//            external win/draw checker. Freezes the board once the checker
//            reports a win or a full board.
// Ports    : clk        - system clock, rising edge
//            rst_n      - asynchronous active-low reset
//            btn[9:1]   - raw cell buttons (async, active-high, row-major)
//            new_game   - synchronous clear request (level)
//            w[3:1]     - checker feedback: P1 win, P2 win, board full
//            sw[18:1]   - marks: sw[2k-1]=P1 owns cell k, sw[2k]=P2 owns k
//            b[9:1]     - occupancy, b[k] = sw[2k-1] | sw[2k]
//            turn       - player to move (0=P1, 1=P2)
//            game_over  - high while the game is finished
//            result     - 01=P1 won, 10=P2 won, 11=draw, 00=in progress
//            illegal    - one-cycle pulse on a rejected press
//            timeout    - one-cycle pulse on a forfeited turn
// Config   : MOVE_TIMEOUT_EN - when defined, an idle counter in S_PLAY
//            forfeits the turn after TIMEOUT_CYCLES cycles without a move.
// Revision : 1.0 - initial release
// ============================================================================
module move_collector #(
   parameter int DB_CYCLES      = 4,
   parameter int FIRST_PLAYER   = 0,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:1]  btn,
   input  logic        new_game,
   input  logic [3:1]  w,
   output logic [18:1] sw,
   output logic [9:1]  b,
   output logic        turn,
   output logic        game_over,
   output logic [1:0]  result,
   output logic        illegal,
   output logic        timeout
);

   localparam int              CNT_W      = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] DB_MAX    = CNT_W'(DB_CYCLES);
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic             FIRST_TURN = (FIRST_PLAYER != 0);

   typedef enum logic [1:0] {
      S_PLAY  = 2'd0,
      S_CHECK = 2'd1,
      S_OVER  = 2'd2
   } state_t;

   state_t      state_q;
   logic [9:1]  sync1_q, sync2_q;
   logic [9:1]  press_d, press_q;
   logic [18:1] sw_q;
   logic [9:1]  b_q;
   logic        turn_q, game_over_q, illegal_q;
   logic [1:0]  result_q;
   logic [18:1] move_mask_d;
   logic        one_hot_d, collide_d, legal_d;

   // ------------------------------------------------------------------
   // Per-cell debounce. The counter saturates at DB_CYCLES, so the
   // "about to reach DB_CYCLES" condition occurs only once per hold and a
   // release (counter back to 0) is required before the cell fires again.
   // ------------------------------------------------------------------
   for (genvar k = 1; k <= 9; k++) begin : g_cell
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
         end else if (!sync2_q[k]) begin
            cnt_q <= '0;
         end else if (cnt_q != DB_MAX) begin
            cnt_q <= cnt_q + CNT_ONE;
         end
      end

      assign press_d[k] = sync2_q[k] && (cnt_q == DB_LAST);

      // Expand the one-hot press into the mark slot of the player to move.
      assign move_mask_d[2*k-1] = press_q[k] & ~turn_q;
      assign move_mask_d[2*k]   = press_q[k] &  turn_q;
   end

   // Two-flop synchronizer plus the registered press pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         press_q <= '0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         press_q <= press_d;
      end
   end

   assign one_hot_d = (press_q != '0) && ((press_q & (press_q - 9'd1)) == '0);
   assign collide_d = |(press_q & b_q);
   assign legal_d   = one_hot_d && !collide_d;

`ifdef MOVE_TIMEOUT_EN
   localparam int            TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
   logic [TO_W-1:0] idle_q;
   logic            timeout_q;
`endif

   // ------------------------------------------------------------------
   // Game FSM; all outputs registered here.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_PLAY;
         sw_q        <= '0;
         b_q         <= '0;
         turn_q      <= FIRST_TURN;
         game_over_q <= 1'b0;
         result_q    <= 2'b00;
         illegal_q   <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
         idle_q      <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         illegal_q <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         if (new_game) begin
            // Overrides any press in the same cycle; debounce is left alone
            // so a held button does not fire again into the new game.
            state_q     <= S_PLAY;
            sw_q        <= '0;
            b_q         <= '0;
            turn_q      <= FIRST_TURN;
            game_over_q <= 1'b0;
            result_q    <= 2'b00;
`ifdef MOVE_TIMEOUT_EN
            idle_q      <= '0;
`endif
         end else begin
            case (state_q)
               S_PLAY: begin
                  if (legal_d) begin
                     sw_q    <= sw_q | move_mask_d;
                     b_q     <= b_q | press_q;
                     state_q <= S_CHECK;
`ifdef MOVE_TIMEOUT_EN
                     idle_q  <= '0;
`endif
                  end else begin
                     if (press_q != '0) begin
                        illegal_q <= 1'b1;
                     end
`ifdef MOVE_TIMEOUT_EN
                     if (idle_q == TO_LAST) begin
                        timeout_q <= 1'b1;
                        turn_q    <= ~turn_q;
                        idle_q    <= '0;
                     end else begin
                        idle_q <= idle_q + TO_ONE;
                     end
`endif
                  end
               end
               S_CHECK: begin
                  // A win outranks "board full": the last move may both
                  // complete a line and fill the board.
                  if (w[1] || w[2] || w[3]) begin
                     result_q    <= w[1] ? 2'b01 : (w[2] ? 2'b10 : 2'b11);
                     game_over_q <= 1'b1;
                     state_q     <= S_OVER;
                  end else begin
                     turn_q  <= ~turn_q;
                     state_q <= S_PLAY;
                  end
`ifdef MOVE_TIMEOUT_EN
                  idle_q <= '0;
`endif
               end
               S_OVER: begin
`ifdef MOVE_TIMEOUT_EN
                  idle_q <= '0;
`endif
               end
               default: begin
                  state_q <= S_PLAY;
               end
            endcase
         end
      end
   end

   assign sw        = sw_q;
   assign b         = b_q;
   assign turn      = turn_q;
   assign game_over = game_over_q;
   assign result    = result_q;
   assign illegal   = illegal_q;
`ifdef MOVE_TIMEOUT_EN
   assign timeout   = timeout_q;
`else
   assign timeout   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_move_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_collector
// Purpose  : Directed self-checking bench for move_collector. A small
//            win/draw checker model feeds w from the DUT's sw/b outputs.
//            With MOVE_TIMEOUT_EN defined, a second idle instance with
//            TIMEOUT_CYCLES=20 exercises the forfeit path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_collector;

   localparam int DB = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:1]  btn = '0;
   logic        new_game = 1'b0;
   logic [3:1]  w;
   logic [18:1] sw;
   logic [9:1]  b;
   logic        turn, game_over, illegal, timeout;
   logic [1:0]  result;

   int n_checks = 0;
   int n_errors = 0;
   int ill_cnt  = 0;
   int to_cnt   = 0;

   always #5 clk = ~clk;

   move_collector #(.DB_CYCLES(DB), .FIRST_PLAYER(0), .TIMEOUT_CYCLES(1000)) dut (
      .clk(clk), .rst_n(rst_n), .btn(btn), .new_game(new_game), .w(w),
      .sw(sw), .b(b), .turn(turn), .game_over(game_over), .result(result),
      .illegal(illegal), .timeout(timeout)
   );

`ifdef MOVE_TIMEOUT_EN
   logic [18:1] to_sw;
   logic [9:1]  to_b;
   logic        to_turn, to_over, to_ill, to_timeout;
   logic [1:0]  to_result;

   move_collector #(.DB_CYCLES(DB), .FIRST_PLAYER(0), .TIMEOUT_CYCLES(20)) dut_to (
      .clk(clk), .rst_n(rst_n), .btn(9'd0), .new_game(1'b0), .w(3'd0),
      .sw(to_sw), .b(to_b), .turn(to_turn), .game_over(to_over), .result(to_result),
      .illegal(to_ill), .timeout(to_timeout)
   );
`endif

   // Checker model: three-in-a-row per player plus board-full.
   function automatic logic has_line(input logic [9:1] m);
      return (m[1] & m[2] & m[3]) | (m[4] & m[5] & m[6]) | (m[7] & m[8] & m[9]) |
             (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) | (m[3] & m[6] & m[9]) |
             (m[1] & m[5] & m[9]) | (m[3] & m[5] & m[7]);
   endfunction

   logic [9:1] p1m, p2m;
   always_comb begin
      p1m = '0;
      p2m = '0;
      for (int k = 1; k <= 9; k++) begin
         p1m[k] = sw[2*k-1];
         p2m[k] = sw[2*k];
      end
      w = {&b, has_line(p2m), has_line(p1m)};
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (illegal) ill_cnt++;
      if (timeout) to_cnt++;
   endtask

   task automatic press(input logic [9:1] m);
      btn = m;
      repeat (DB + 4) tick();
      btn = '0;
      repeat (4) tick();
   endtask

   task automatic move(input int k);
      logic [9:1] m;
      m = '0;
      m[k] = 1'b1;
      press(m);
   endtask

   task automatic start_new();
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- Reset values ----------------
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_sw", 32'(sw), 32'h0);
      check_val("rst_b", 32'(b), 32'h0);
      check_val("rst_turn", 32'(turn), 32'h0);
      check_val("rst_over", 32'(game_over), 32'h0);
      check_val("rst_result", 32'(result), 32'h0);
      check_val("rst_illegal", 32'(illegal), 32'h0);
      check_val("rst_timeout", 32'(timeout), 32'h0);
      rst_n = 1'b1;

      // ---------------- Idle / timeout ----------------
      for (int i = 1; i <= 100; i++) begin
         tick();
`ifdef MOVE_TIMEOUT_EN
         if (i == 19) begin
            check_val("to_pre_pulse", 32'(to_timeout), 32'h0);
            check_val("to_pre_turn", 32'(to_turn), 32'h0);
         end
         if (i == 20) begin
            check_val("to_pulse", 32'(to_timeout), 32'h1);
            check_val("to_turn", 32'(to_turn), 32'h1);
         end
         if (i == 21) check_val("to_pulse_end", 32'(to_timeout), 32'h0);
`endif
      end
      check_val("idle_turn", 32'(turn), 32'h0);
      check_val("idle_no_timeout", 32'(to_cnt), 32'h0);

      // ---------------- Test 1: latency of a single press ----------------
      btn = 9'h010;
      repeat (6) tick();
      check_val("t1_b_before", 32'(b), 32'h0);
      tick();
      check_val("t1_sw_c7", 32'(sw), 32'h00100);
      check_val("t1_b_c7", 32'(b), 32'h010);
      check_val("t1_turn_c7", 32'(turn), 32'h0);
      tick();
      check_val("t1_turn_c8", 32'(turn), 32'h1);
      repeat (2) tick();
      btn = '0;
      repeat (4) tick();
      check_val("t1_single_move", 32'(sw), 32'h00100);

      // ---------------- Test 3: illegal presses ----------------
      ill_cnt = 0;
      press(9'h010);
      check_val("t3_occ_pulses", 32'(ill_cnt), 32'h1);
      check_val("t3_occ_sw", 32'(sw), 32'h00100);
      check_val("t3_occ_turn", 32'(turn), 32'h1);
      ill_cnt = 0;
      press(9'h003);
      check_val("t3_multi_pulses", 32'(ill_cnt), 32'h1);
      check_val("t3_multi_b", 32'(b), 32'h010);
      check_val("t3_multi_turn", 32'(turn), 32'h1);

      // ---------------- new_game clears ----------------
      start_new();
      check_val("ng_sw", 32'(sw), 32'h0);
      check_val("ng_b", 32'(b), 32'h0);
      check_val("ng_turn", 32'(turn), 32'h0);

      // ---------------- Test 2: P1 wins on top row ----------------
      move(1); move(4); move(2); move(5); move(3);
      check_val("t2_result", 32'(result), 32'h1);
      check_val("t2_over", 32'(game_over), 32'h1);
      check_val("t2_sw", 32'(sw), 32'h00295);
      check_val("t2_b", 32'(b), 32'h01F);
      ill_cnt = 0;
      move(9);
      move(1);
      check_val("t2_frozen_sw", 32'(sw), 32'h00295);
      check_val("t2_frozen_noill", 32'(ill_cnt), 32'h0);
      check_val("t2_frozen_result", 32'(result), 32'h1);

      // ---------------- Test 4: draw, then win on full board ----------------
      start_new();
      check_val("t4_ng_over", 32'(game_over), 32'h0);
      move(1); move(2); move(3); move(5); move(4); move(6); move(8); move(7); move(9);
      check_val("t4_draw_result", 32'(result), 32'h3);
      check_val("t4_draw_b", 32'(b), 32'h1FF);
      check_val("t4_draw_sw", 32'(sw), 32'h16A59);
      start_new();
      move(1); move(2); move(4); move(3); move(6); move(5); move(8); move(9); move(7);
      check_val("t4_fullwin_result", 32'(result), 32'h1);
      check_val("t4_fullwin_b", 32'(b), 32'h1FF);
      check_val("t4_fullwin_sw", 32'(sw), 32'h25669);

      // ---------------- Test 5: new_game beats a simultaneous press ----------------
      start_new();
      move(1);
      check_val("t5_turn_mid", 32'(turn), 32'h1);
      btn = 9'h004;
      repeat (DB + 2) tick();
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      check_val("t5_sw", 32'(sw), 32'h0);
      check_val("t5_b", 32'(b), 32'h0);
      check_val("t5_turn", 32'(turn), 32'h0);
      repeat (6) tick();
      check_val("t5_no_refire", 32'(b), 32'h0);
      btn = '0;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
